ex_mem: RTL

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS32 core. Each clock it captures the execute stage's write-back request (enable, destination register, result), holds it under stall, inserts a bubble when execute stalls but memory does not, and clears it on flush. It also presents registered-result forwarding to the decode stage and a saturating hold-cycle counter for performance debug.

---
 rtl/ex_mem.sv | 85 ++++++++
 1 files changed

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with zero-register gating, MEM->ID forwarding and a saturating hold counter.
// One-cycle latency; stall[4] holds contents, stall[3] alone loads a bubble, flush always loads a bubble.
module ex_mem #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               ex_writeReg,
  input  logic [4:0]         ex_writeAddr,
  input  logic [31:0]        ex_writeData,
  output logic               mem_writeReg,
  output logic [4:0]         mem_writeAddr,
  output logic [31:0]        mem_writeData,
  output logic               mem_valid,
  input  logic [4:0]         id_readAddr1,
  input  logic [4:0]         id_readAddr2,
  output logic               fwdHit1,
  output logic               fwdHit2,
  output logic [31:0]        fwdData1,
  output logic [31:0]        fwdData2,
  output logic [CNT_W-1:0]   holdCount
);

  logic             r_wr;
  logic [4:0]       r_addr;
  logic [31:0]      r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_hold;

  logic w_hold;
  logic w_bubble;
  logic w_hit1;
  logic w_hit2;
  logic w_unused;

  // Flush dominates; a memory stall holds even if execute is not stalled.
  assign w_hold   = ~flush & stall[4];
  assign w_bubble = flush | (~stall[4] & stall[3]);
  assign w_unused = &{1'b0, stall[2:0], stall[STALL_W-1:5]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_wr    <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_valid <= 1'b0;
    end else if (!w_hold) begin
      r_wr    <= ex_writeReg & (ex_writeAddr != 5'd0);
      r_addr  <= ex_writeAddr;
      r_data  <= ex_writeData;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_hold && (r_hold != {CNT_W{1'b1}})) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Forwarding looks only at registered state, never at the ex_* inputs.
  assign w_hit1 = r_valid & r_wr & (id_readAddr1 == r_addr) & (id_readAddr1 != 5'd0);
  assign w_hit2 = r_valid & r_wr & (id_readAddr2 == r_addr) & (id_readAddr2 != 5'd0);

  assign mem_writeReg  = r_wr;
  assign mem_writeAddr = r_addr;
  assign mem_writeData = r_data;
  assign mem_valid     = r_valid;
  assign fwdHit1       = w_hit1;
  assign fwdHit2       = w_hit2;
  assign fwdData1      = w_hit1 ? r_data : 32'd0;
  assign fwdData2      = w_hit2 ? r_data : 32'd0;
  assign holdCount     = r_hold;

endmodule
